// File: rtl/lzss_window_buffer.sv
// lzss_window_buffer
// Multi-lane sliding-window buffer for the LZSS dictionary/look-ahead path.
// Up to pLanes symbols are accepted per cycle. The whole window shifts by the
// accepted count, so the newest symbol always lands in entry pDepth-1.
// Every window entry, the valid count and the full flag are registered.
// Nothing passes combinationally from i_d to o_d.
//
// Optional build macro: LZSS_WINDOW_VALID_MASK_EN
//   Adds o_vmask[pDepth-1:0]. Bit i is set when entry i holds valid data.
//
// Handshake (valid/ready): a transfer happens at a rising clk edge when
// i_vld and o_rdy are both high and i_clear is low. i_num/i_d are sampled
// only on that edge. o_rdy is registered and depends only on reset and
// i_clear, never on i_vld, so the buffer never stalls a shift. When the
// window is full, the oldest entries fall out.

module lzss_window_buffer #(
   parameter int pWidth      = 8,
   parameter int pDepth      = 64,
   parameter int pLanes      = 4,
   parameter int pNumWidth   = 3,
   parameter int pCountWidth = 7,
   parameter int pTotalWidth = pWidth * pDepth
) (
   input  logic                      clk,
   input  logic                      rst_x,
   input  logic                      i_clear,
   input  logic                      i_vld,
   output logic                      o_rdy,
   input  logic [pNumWidth-1:0]      i_num,
   input  logic [pLanes*pWidth-1:0]  i_d,
   output logic [pTotalWidth-1:0]    o_d,
   output logic [pCountWidth-1:0]    o_count,
   output logic                      o_full
`ifdef LZSS_WINDOW_VALID_MASK_EN
   ,
   output logic [pDepth-1:0]         o_vmask
`endif
);

   localparam int cExtWidth = (pDepth + pLanes) * pWidth;

   logic [pTotalWidth-1:0] win_q;
   logic [pTotalWidth-1:0] win_nxt;
   logic [cExtWidth-1:0]   ext;
   logic [pCountWidth-1:0] cnt_q;
   logic [pCountWidth-1:0] cnt_nxt;
   logic [pCountWidth:0]   sum;
   logic                   full_q;
   logic                   full_nxt;
   logic                   rdy_q;
   logic                   accept;
   logic [pNumWidth-1:0]   n_eff;

   // Transfer qualifier and the lane count after clamping to pLanes.
   always_comb begin
      accept = i_vld & rdy_q & ~i_clear;
      n_eff  = i_num;
      if (i_num > pNumWidth'(pLanes)) begin
         n_eff = pNumWidth'(pLanes);
      end
   end

   // The incoming lanes sit directly above the oldest-first window.
   // Entry i of the shifted window is element i+n of the concatenation.
   // Old entries come from below pDepth and new lanes from above it.
   assign ext = {i_d, win_q};

   // Next window: clear wins, and an accepted transfer shifts by n_eff.
   always_comb begin
      win_nxt = win_q;
      if (i_clear) begin
         win_nxt = '0;
      end else if (accept) begin
         for (int i = 0; i < pDepth; i++) begin
            win_nxt[i*pWidth +: pWidth] = ext[(i + int'(n_eff))*pWidth +: pWidth];
         end
      end
   end

   // Next count: the sum saturates at pDepth. The sum is one bit wider so it never wraps.
   always_comb begin
      sum     = {1'b0, cnt_q} + (pCountWidth+1)'(n_eff);
      cnt_nxt = cnt_q;
      if (i_clear) begin
         cnt_nxt = '0;
      end else if (accept) begin
         if (sum > (pCountWidth+1)'(pDepth)) begin
            cnt_nxt = pCountWidth'(pDepth);
         end else begin
            cnt_nxt = sum[pCountWidth-1:0];
         end
      end
      full_nxt = (cnt_nxt == pCountWidth'(pDepth));
   end

   // Window, count, full flag and ready register. Reset returns everything to zero.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         win_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         win_q  <= win_nxt;
         cnt_q  <= cnt_nxt;
         full_q <= full_nxt;
         rdy_q  <= ~i_clear;
      end
   end

`ifdef LZSS_WINDOW_VALID_MASK_EN
   logic [pDepth-1:0] vmask_q;
   logic [pDepth-1:0] vmask_nxt;

   // Valid entries are packed at the newest end. Bit i is set when i >= pDepth - count.
   always_comb begin
      vmask_nxt = '0;
      for (int i = 0; i < pDepth; i++) begin
         vmask_nxt[i] = (i >= (pDepth - int'(cnt_nxt)));
      end
   end

   // Mask register. It tracks the count register edge for edge.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         vmask_q <= '0;
      end else begin
         vmask_q <= vmask_nxt;
      end
   end

   assign o_vmask = vmask_q;
`endif

   assign o_d     = win_q;
   assign o_count = cnt_q;
   assign o_full  = full_q;
   assign o_rdy   = rdy_q;

endmodule

// File: tb/tb_lzss_window_buffer.sv
// tb_lzss_window_buffer
// The bench keeps a reference model of the window as a queue of symbols,
// oldest first. An accepted transfer pushes lanes at the back and pops the
// same number from the front. The count is min(count + n, depth).
// Directed steps follow the feature list. Randomized traffic follows them.

module tb_lzss_window_buffer;

   localparam int W     = 8;
   localparam int D     = 64;
   localparam int L     = 4;
   localparam int NW    = 3;
   localparam int CW    = 7;
   localparam int TOTAL = W * D;

   logic               clk = 1'b0;
   logic               rst_x;
   logic               i_clear;
   logic               i_vld;
   logic               o_rdy;
   logic [NW-1:0]      i_num;
   logic [L*W-1:0]     i_d;
   logic [TOTAL-1:0]   o_d;
   logic [CW-1:0]      o_count;
   logic               o_full;
`ifdef LZSS_WINDOW_VALID_MASK_EN
   logic [D-1:0]       o_vmask;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [W-1:0] exp_q[$];
   int           exp_cnt;
   bit           exp_rdy;

   lzss_window_buffer #(
      .pWidth(W), .pDepth(D), .pLanes(L), .pNumWidth(NW), .pCountWidth(CW)
   ) dut (
      .clk     (clk),
      .rst_x   (rst_x),
      .i_clear (i_clear),
      .i_vld   (i_vld),
      .o_rdy   (o_rdy),
      .i_num   (i_num),
      .i_d     (i_d),
      .o_d     (o_d),
      .o_count (o_count),
`ifdef LZSS_WINDOW_VALID_MASK_EN
      .o_vmask (o_vmask),
`endif
      .o_full  (o_full)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [TOTAL-1:0] got,
                        input logic [TOTAL-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q = {};
      for (int i = 0; i < D; i++) exp_q.push_back('0);
      exp_cnt = 0;
      exp_rdy = 1'b0;
   endtask

   // Compare every output against the model.
   task automatic check_all(input string tag);
      logic [TOTAL-1:0] exp_od;
      logic [D-1:0]     exp_vm;
      exp_od = '0;
      exp_vm = '0;
      for (int i = 0; i < D; i++) begin
         exp_od[i*W +: W] = exp_q[i];
         exp_vm[i] = (i >= D - exp_cnt);
      end
      check({tag, "_od"},    o_d, exp_od);
      check({tag, "_count"}, TOTAL'(o_count), TOTAL'(exp_cnt));
      check({tag, "_full"},  TOTAL'(o_full), TOTAL'(exp_cnt == D));
      check({tag, "_rdy"},   TOTAL'(o_rdy), TOTAL'(exp_rdy));
`ifdef LZSS_WINDOW_VALID_MASK_EN
      check({tag, "_vmask"}, TOTAL'(o_vmask), TOTAL'(exp_vm));
`else
      if (exp_vm[0] === 1'bx) check({tag, "_vm"}, '0, '1);
`endif
   endtask

   task automatic drive(input bit vld, input int num, input logic [W-1:0] l0,
                        input logic [W-1:0] l1, input logic [W-1:0] l2,
                        input logic [W-1:0] l3, input bit clr);
      i_vld   = vld;
      i_num   = NW'(num);
      i_d     = {l3, l2, l1, l0};
      i_clear = clr;
   endtask

   // Advance one edge. Apply the model rules to the inputs seen at that edge, then compare.
   task automatic tick(input string tag);
      bit acc;
      int n;
      acc = i_vld && exp_rdy && !i_clear;
      n   = (int'(i_num) > L) ? L : int'(i_num);
      @(posedge clk);
      #1;
      if (i_clear) begin
         foreach (exp_q[i]) exp_q[i] = '0;
         exp_cnt = 0;
      end else if (acc) begin
         for (int k = 0; k < n; k++) begin
            exp_q.push_back(i_d[k*W +: W]);
            void'(exp_q.pop_front());
         end
         exp_cnt = (exp_cnt + n > D) ? D : exp_cnt + n;
      end
      exp_rdy = !i_clear;
      check_all(tag);
   endtask

   initial begin
      // reset
      rst_x = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst_x = 1'b1;
      #1;
      check("rdy_first_cycle", TOTAL'(o_rdy), '0);
      tick("rdy_rise");
      check("rdy_up", TOTAL'(o_rdy), TOTAL'(1));

      // single-symbol push
      drive(1, 1, 8'hA5, 8'h11, 8'h22, 8'h33, 0);
      tick("single");
      check("single_e63", TOTAL'(o_d[63*W +: W]), TOTAL'(8'hA5));
      check("single_low", TOTAL'(o_d[63*W-1:0]), '0);
      check("single_cnt", TOTAL'(o_count), TOTAL'(1));

      // multi-lane push, lane 3 ignored
      drive(1, 3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0);
      tick("multi");
      check("multi_top", TOTAL'(o_d[60*W +: 4*W]), TOTAL'(32'hB2B1B0A5));
      check("multi_cnt", TOTAL'(o_count), TOTAL'(4));

      // clear, then saturation from empty
      drive(0, 0, 0, 0, 0, 0, 1);
      tick("clr");
      drive(0, 0, 0, 0, 0, 0, 0);
      tick("clr_idle");
      for (int a = 0; a < 17; a++) begin
         drive(1, 4, W'(4*a), W'(4*a+1), W'(4*a+2), W'(4*a+3), 0);
         tick("sat");
         if (a == 14) check("sat_notfull15", TOTAL'(o_full), '0);
         if (a == 15) begin
            check("sat_cnt16", TOTAL'(o_count), TOTAL'(64));
            check("sat_full16", TOTAL'(o_full), TOTAL'(1));
         end
      end
      check("sat_e0", TOTAL'(o_d[0 +: W]), TOTAL'(8'h04));
      check("sat_e63", TOTAL'(o_d[63*W +: W]), TOTAL'(8'h43));
      check("sat_cnt17", TOTAL'(o_count), TOTAL'(64));

      // clear collides with valid
      drive(1, 2, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1);
      tick("coll");
      check("coll_od", o_d, '0);
      check("coll_cnt", TOTAL'(o_count), '0);
      check("coll_rdy", TOTAL'(o_rdy), '0);
      drive(1, 2, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 0);
      tick("coll_after");
      check("coll_noacc", TOTAL'(o_count), '0);
      check("coll_rdy_back", TOTAL'(o_rdy), TOTAL'(1));

      // clamp and zero
      drive(1, 7, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 0);
      tick("clamp");
      check("clamp_top", TOTAL'(o_d[60*W +: 4*W]), TOTAL'(32'hD3D2D1D0));
      check("clamp_cnt", TOTAL'(o_count), TOTAL'(4));
      drive(1, 0, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 0);
      tick("zero");
      check("zero_top", TOTAL'(o_d[60*W +: 4*W]), TOTAL'(32'hD3D2D1D0));
      check("zero_cnt", TOTAL'(o_count), TOTAL'(4));

      // asynchronous reset mid-operation
      drive(1, 2, 8'h5A, 8'h5B, 8'h00, 8'h00, 0);
      tick("pre_rst");
      #3;
      rst_x = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_x = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick("post_rst");

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
               W'($urandom), W'($urandom), W'($urandom), W'($urandom),
               $urandom_range(0, 15) == 0);
         tick("rand");
      end

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lzss_window_buffer.md
Name: lzss_window_buffer

Overview:
- Multi-lane sliding-window buffer for the LZSS compressor dictionary/look-ahead path.
- Accepts up to pLanes symbols per cycle over a valid/ready handshake.
- Shifts the whole window by the accepted symbol count and tracks how many entries hold valid data.
- Every window entry is registered. The newest symbol is visible on o_d one cycle after acceptance; there is no combinational input passthrough.

Parameters:
- pWidth, 8: symbol width in bits.
- pDepth, 64: window depth in symbols. Must be at least pLanes.
- pLanes, 4: maximum symbols accepted per cycle. Range 1..pDepth.
- pNumWidth, 3: width of i_num. Must represent pLanes.
- pCountWidth, 7: width of o_count. Must represent pDepth.
- pTotalWidth, pWidth*pDepth: derived width of o_d.

Ports:
- clk, input, 1: clock.
- rst_x, input, 1: asynchronous reset, active low.
- i_clear, input, 1: synchronous clear of window and count.
- i_vld, input, 1: input symbols valid.
- o_rdy, output, 1: buffer ready to accept.
- i_num, input, pNumWidth: number of symbols offered, 0..pLanes.
- i_d, input, pLanes*pWidth: symbols. Lane k is i_d[k*pWidth+:pWidth]; lane 0 is the oldest.
- o_d, output, pTotalWidth: window contents. Entry i is o_d[i*pWidth+:pWidth]; entry pDepth-1 is the newest.
- o_count, output, pCountWidth: number of valid entries, 0..pDepth.
- o_full, output, 1: o_count == pDepth.

Behaviour:
- Reset state (rst_x low): all entries 0, o_count 0, o_full 0, o_rdy 0.
- o_rdy is registered:
  - Rises on the first clk edge after rst_x deasserts.
  - Falls on the edge where i_clear is sampled high.
  - Rises again on the first edge where i_clear is sampled low.
- Accept condition: i_vld & o_rdy & !i_clear at a clk edge.
- Effective count n = min(i_num, pLanes). Values above pLanes are clamped.
- On accept with n > 0:
  - Entry i takes old entry i+n, for i < pDepth-n.
  - Entry pDepth-n+k takes lane k, for k in 0..n-1.
  - The n oldest entries are discarded.
  - Lanes n..pLanes-1 are ignored.
- On accept with n = 0: the transfer completes but the window and count are unchanged.
- o_count on accept = min(o_count + n, pDepth). Saturating; the sum is computed at pCountWidth+1 bits. o_full is registered and updated in the same cycle.
- A window shift never blocks: when full, the oldest entries fall out and o_count stays at pDepth.
- No accept: window and count hold.
- i_clear high at an edge:
  - All entries and o_count go to 0, o_full goes to 0.
  - i_clear overrides a simultaneous i_vld; those symbols are not accepted.
  - o_rdy is 0 in the following cycle.
- Reset asserted mid-operation returns all state to the reset values asynchronously. There is no partial-shift state.
- Latency: symbols accepted at edge t appear on o_d and are counted in o_count after edge t.

Optional Feature:
- Macro: LZSS_WINDOW_VALID_MASK_EN.
- Defined:
  - Adds output o_vmask [pDepth-1:0].
  - Bit i = 1 iff entry i holds valid data, i.e. i >= pDepth - o_count.
  - o_vmask is registered and updated on the same edge as o_d and o_count. Reset/clear value is all zeros; full is all ones.
  - Downstream match logic uses it to ignore empty entries.
- Not defined: the port is absent and no mask logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset release: rst_x 0 -> 1 -> o_rdy 0 in the first cycle, 1 from the next. o_d all 0, o_count 0, o_full 0.
- Single-symbol push: i_num=1, i_d lane0=0xA5, one accept -> entry 63 = 0xA5, entries 0..62 = 0, o_count 1 (mask bit 63 only when LZSS_WINDOW_VALID_MASK_EN).
- Multi-lane push: after the previous step, i_num=3, lanes 0xB0, 0xB1, 0xB2, 0xB3 -> entries 60..63 = 0xA5, 0xB0, 0xB1, 0xB2; o_count 4; lane 3 ignored.
- Saturation: 17 accepts of i_num=4 with incrementing bytes 0x00..0x43 -> o_count 64 and o_full 1 after the 16th accept. After the 17th, entry 0 = 0x04, entry 63 = 0x43, o_count stays 64.
- Clear collision: i_clear=1 together with i_vld=1, i_num=2 -> all entries 0, o_count 0, o_rdy 0 next cycle. The symbols do not appear. o_rdy returns 1 the cycle after i_clear drops.
- Clamp and zero: i_num=7 with pLanes=4 -> behaves as n=4. i_num=0 with i_vld=1 -> window and o_count unchanged.
